// File: rtl/button_event_gen.sv
// rtl/button_event_gen.sv - per-channel press/release/long/repeat event generator
module button_event_gen #(
  parameter int w             = 1,
  parameter int cnt_width     = 24,
  parameter int long_cycles   = 12_500_000,
  parameter int repeat_cycles = 2_500_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [w-1:0] btn_in,
  output logic [w-1:0] press_pulse,
  output logic [w-1:0] release_pulse,
  output logic [w-1:0] long_pulse,
  output logic [w-1:0] repeat_pulse,
  output logic [w-1:0] held
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  // Terminal counts: the counter starts at 0 on entry, so expiry is at N-1.
  localparam logic [cnt_width-1:0] LONG_LAST   = cnt_width'(long_cycles - 1);
  localparam logic [cnt_width-1:0] REPEAT_LAST =
    cnt_width'((repeat_cycles > 0) ? (repeat_cycles - 1) : 0);
  localparam logic [cnt_width-1:0] CNT_ONE     = cnt_width'(1);

  genvar g;
  generate
    for (g = 0; g < w; g++) begin : g_ch
      state_t               r_state;
      logic [cnt_width-1:0] r_cnt;
      logic                 r_btn_prev;
      logic                 r_press;
      logic                 r_release;
      logic                 r_long;
      logic                 r_repeat;
      logic                 r_held;
      logic                 w_btn;

      assign w_btn = btn_in[g];

      // Channel FSM: release always wins over a simultaneous long/repeat expiry.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_state    <= ST_IDLE;
          r_cnt      <= '0;
          r_btn_prev <= 1'b0;
          r_press    <= 1'b0;
          r_release  <= 1'b0;
          r_long     <= 1'b0;
          r_repeat   <= 1'b0;
          r_held     <= 1'b0;
        end else begin
          r_btn_prev <= w_btn;
          r_press    <= 1'b0;
          r_release  <= 1'b0;
          r_long     <= 1'b0;
          r_repeat   <= 1'b0;
          case (r_state)
            ST_IDLE: begin
              if (w_btn && !r_btn_prev) begin
                r_state <= ST_PRESSED;
                r_cnt   <= '0;
                r_press <= 1'b1;
                r_held  <= 1'b1;
              end
            end
            ST_PRESSED: begin
              if (!w_btn) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_release <= 1'b1;
                r_held    <= 1'b0;
              end else if (r_cnt == LONG_LAST) begin
                r_state <= ST_LONG;
                r_cnt   <= '0;
                r_long  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            ST_LONG: begin
              if (!w_btn) begin
                r_state   <= ST_IDLE;
                r_cnt     <= '0;
                r_release <= 1'b1;
                r_held    <= 1'b0;
              end else if (repeat_cycles == 0) begin
                r_cnt <= '0;
              end else if (r_cnt == REPEAT_LAST) begin
                r_cnt    <= '0;
                r_repeat <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            default: begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
              r_held  <= 1'b0;
            end
          endcase
        end
      end

      assign press_pulse[g]   = r_press;
      assign release_pulse[g] = r_release;
      assign long_pulse[g]    = r_long;
      assign repeat_pulse[g]  = r_repeat;
      assign held[g]          = r_held;
    end
  endgenerate

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 Parameter w, default 1: number of independent button channels.
REQ-002 Parameter cnt_width, default 24: width of each channel's hold counter.
REQ-003 Parameter long_cycles, default 12_500_000: hold cycles from press to long-press event; legal range 2 .. 2^cnt_width-1.
REQ-004 Parameter repeat_cycles, default 2_500_000: cycles between auto-repeat events after long press; 0 disables repeat; otherwise legal range 1 .. 2^cnt_width-1.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 btn_in  input  w  debounced, clk-synchronous button levels, 1 = pressed.
REQ-008 press_pulse  output  w  one-cycle strobe per channel on press.
REQ-009 release_pulse  output  w  one-cycle strobe per channel on release.
REQ-010 long_pulse  output  w  one-cycle strobe when hold reaches long_cycles.
REQ-011 repeat_pulse  output  w  one-cycle strobe every repeat_cycles while in long hold.
REQ-012 held  output  w  level, 1 while the channel is in PRESSED or LONG.

Function
REQ-013 Channels SHALL be fully independent: per-channel btn_prev register, state, and counter.
REQ-014 Per-channel FSM states SHALL be IDLE, PRESSED and LONG.
REQ-015 All outputs SHALL be registered; each event pulse SHALL be high for exactly one clk cycle.
REQ-016 Press: btn_in=1 with btn_prev=0 sampled in IDLE -> PRESSED, cnt=0, press_pulse=1 on the following cycle (latency 1 clk from the input edge).
REQ-017 PRESSED with btn_in=1 -> cnt increments by 1 each cycle; when cnt = long_cycles-1 -> LONG, cnt=0, long_pulse=1.
REQ-018 The first long_pulse SHALL be asserted exactly long_cycles cycles after press_pulse.
REQ-019 LONG with repeat_cycles>0 and btn_in=1 -> cnt increments; when cnt = repeat_cycles-1 -> cnt=0, repeat_pulse=1, remain LONG.
REQ-020 LONG with repeat_cycles=0 -> cnt held at 0 and repeat_pulse never asserted.
REQ-021 Release: btn_in=0 sampled in PRESSED or LONG -> IDLE, cnt=0, release_pulse=1 on the following cycle.
REQ-022 Release in the same cycle as long or repeat expiry SHALL take priority: only release_pulse is asserted, with no long_pulse or repeat_pulse.
REQ-023 btn_in=0 in IDLE SHALL produce no event; counters never wrap, since they clear on every expiry.
REQ-024 held SHALL be 1 from the cycle press_pulse is asserted through the last cycle before release_pulse is asserted, and 0 from the release_pulse cycle onward.
REQ-025 The w=1 build SHALL need no logic beyond one channel.

Reset
REQ-026 While reset=1: all outputs 0, all states IDLE, all cnt 0, all btn_prev 0, applied asynchronously.
REQ-027 If btn_in=1 when reset deasserts, the first clock edge after reset deassertion SHALL be treated as a press, since btn_prev=0; press_pulse follows 1 cycle later.
REQ-028 Reset asserted mid-hold (PRESSED or LONG) SHALL abort without emitting release_pulse.

Verification (w=2, long_cycles=8, repeat_cycles=4, cnt_width=4)
REQ-029 Short tap on ch0: btn_in[0] high 3 cycles -> press_pulse[0] 1 cycle after the rise, release_pulse[0] 1 cycle after the fall, no long_pulse, held[0] high 3 cycles.
REQ-030 Long hold on ch0: btn_in[0] high 20 cycles -> long_pulse at press+8; repeat_pulse at press+12, +16 and +20 only if still held (release priority check at +20); then release_pulse.
REQ-031 Boundary on ch0: release sampled on exactly the long-expiry cycle (hold 8 cycles) -> release_pulse only, long_pulse never asserted; repeat the check at a repeat expiry.
REQ-032 Independence: ch1 pressed while ch0 is in LONG -> ch1 press_pulse; ch0 repeat cadence is unchanged, with no cross-channel pulses.
REQ-033 Reset mid-LONG -> all outputs 0 immediately; if btn_in still 1 at deassert, press_pulse 1 cycle after the first post-reset edge.
REQ-034 repeat_cycles=0 build: 30-cycle hold -> exactly one long_pulse and zero repeat_pulse.
